alu_seq_core: RTL and testbench

- Parametrised, handshaked successor to the 8-bit combinational ALU. Same 16-entry 4-bit opcode map.
- Width is generic, and a 4-bit flag register is held internally. The flag register supplies carry-in for ADD/SUB/rotate.
- Rotates are multi-bit and multi-cycle; each request carries a rotate count.
- Sits between the decode stage and the register-file write-back; the result and flags are held until the consumer accepts them.

---
 rtl/alu_seq_core_if.sv | 36 +++
 rtl/alu_seq_core.sv | 225 ++++++++++++++++++++++
 tb/tb_alu_seq_core.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_core_if.sv
// alu_seq_core_if: request/result handshake bundle for alu_seq_core.
// flag_o is 5 bits wide when ALU_OVF_EN is defined, 4 bits otherwise.
interface alu_seq_core_if #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH + 1)
);
`ifdef ALU_OVF_EN
    localparam int FW = 5;
`else
    localparam int FW = 4;
`endif

    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic [SHW-1:0]   shamt_i;
    logic             flag_clr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result_o;
    logic [FW-1:0]    flag_o;

    modport master (
        output in_valid, op_i, a_i, b_i, shamt_i,
        output flag_clr, out_ready,
        input  in_ready, out_valid, result_o, flag_o
    );

    modport slave (
        input  in_valid, op_i, a_i, b_i, shamt_i,
        input  flag_clr, out_ready,
        output in_ready, out_valid, result_o, flag_o
    );
endinterface

// File: rtl/alu_seq_core.sv
// alu_seq_core: handshaked ALU with internal flags and multi-cycle rotates.
// Optional ALU_OVF_EN adds a signed-overflow flag as flag_o[4].
module alu_seq_core #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH + 1)
) (
    input logic           clk,
    input logic           rst_n,
    alu_seq_core_if.slave bus
);
`ifdef ALU_OVF_EN
    localparam int FW = 5;
`else
    localparam int FW = 4;
`endif

    localparam logic [WIDTH:0] ONE_X =
        {{WIDTH{1'b0}}, 1'b1};
    localparam logic [SHW-1:0] CNT_ONE =
        {{(SHW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE,
        ROT,
        HOLD
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] rot_data;
    logic             rot_c;
    logic             rot_left;
    logic [SHW-1:0]   cnt;
    logic [FW-1:0]    flags;
    logic [WIDTH-1:0] result;

    logic             c_in;
    logic             is_rot;
    logic             rot_start;
    logic [WIDTH:0]   ax;
    logic [WIDTH:0]   bx;
    logic [WIDTH:0]   cx;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic [WIDTH-1:0] step_data;
    logic             step_c;
    logic [3:0]       alu_base;
    logic [3:0]       step_base;
    logic [FW-1:0]    alu_flags;
    logic [FW-1:0]    step_flags;

    // A clear coinciding with a request wins, so the op sees C=0.
    assign c_in      = bus.flag_clr ? 1'b0 : flags[1];
    assign is_rot    = (bus.op_i == 4'h6) || (bus.op_i == 4'h7);
    assign rot_start = is_rot && (bus.shamt_i != '0);

    assign ax = {1'b0, bus.a_i};
    assign bx = {1'b0, bus.b_i};
    assign cx = {{WIDTH{1'b0}}, c_in};

    // Single-cycle datapath; MSB of sum is carry/borrow.
    always_comb begin
        sum = '0;
        unique case (bus.op_i)
            4'h0: sum = '0;
            4'h1: sum = ax;
            4'h2: sum = {1'b0, ~bus.a_i};
            4'h3: sum = bx;
            4'h4: sum = ax + ONE_X;
            4'h5: sum = ax - ONE_X;
            4'h6: sum = {c_in, bus.a_i};
            4'h7: sum = {c_in, bus.a_i};
            4'h8: sum = ax + bx;
            4'h9: sum = ax - bx;
            4'hA: sum = ax + bx + cx;
            4'hB: sum = ax - bx - cx;
            4'hC: sum = {1'b0, bus.a_i & bus.b_i};
            4'hD: sum = {1'b0, bus.a_i | bus.b_i};
            4'hE: sum = {1'b0, bus.a_i ^ bus.b_i};
            4'hF: sum = {1'b0, ~(bus.a_i ^ bus.b_i)};
            default: sum = '0;
        endcase
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
    end

    // One bit of rotate-through-carry on the working register.
    always_comb begin
        step_data = rot_data;
        step_c    = rot_c;
        if (rot_left) begin
            step_data = {rot_data[WIDTH-2:0], rot_c};
            step_c    = rot_data[WIDTH-1];
        end else begin
            step_data = {rot_c, rot_data[WIDTH-1:1]};
            step_c    = rot_data[0];
        end
    end

    assign alu_base = {^alu_res,
                       ~alu_res[WIDTH-1],
                       alu_c,
                       ~|alu_res};
    assign step_base = {^step_data,
                        ~step_data[WIDTH-1],
                        step_c,
                        ~|step_data};

`ifdef ALU_OVF_EN
    logic alu_v;
    logic sa;
    logic sb;
    logic sr;

    assign sa = bus.a_i[WIDTH-1];
    assign sb = bus.b_i[WIDTH-1];
    assign sr = alu_res[WIDTH-1];

    // Signed overflow for the arithmetic ops only.
    always_comb begin
        alu_v = 1'b0;
        unique case (bus.op_i)
            4'h4:       alu_v = ~sa & sr;
            4'h5:       alu_v = sa & ~sr;
            4'h8, 4'hA: alu_v = (sa == sb) & (sr != sa);
            4'h9, 4'hB: alu_v = (sa != sb) & (sr != sa);
            default:    alu_v = 1'b0;
        endcase
    end

    assign alu_flags  = {alu_v, alu_base};
    assign step_flags = {1'b0, step_base};
`else
    assign alu_flags  = alu_base;
    assign step_flags = step_base;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    state_nxt = rot_start ? ROT : HOLD;
                end
            end
            ROT: begin
                if (cnt == CNT_ONE) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decoded from state.
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        unique case (state)
            IDLE:    bus.in_ready  = 1'b1;
            HOLD:    bus.out_valid = 1'b1;
            default: ;
        endcase
    end

    // Operand capture, rotate stepping and result/flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rot_data <= '0;
            rot_c    <= 1'b0;
            rot_left <= 1'b0;
            cnt      <= '0;
            result   <= '0;
            flags    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid && rot_start) begin
                        rot_data <= bus.a_i;
                        rot_c    <= c_in;
                        rot_left <= ~bus.op_i[0];
                        cnt      <= bus.shamt_i;
                        if (bus.flag_clr) begin
                            flags <= '0;
                        end
                    end else if (bus.in_valid) begin
                        result <= alu_res;
                        flags  <= alu_flags;
                    end else if (bus.flag_clr) begin
                        flags <= '0;
                    end
                end
                ROT: begin
                    rot_data <= step_data;
                    rot_c    <= step_c;
                    cnt      <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        result <= step_data;
                        flags  <= step_flags;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.result_o = result;
    assign bus.flag_o   = flags;
endmodule

// File: tb/tb_alu_seq_core.sv
// tb_alu_seq_core: directed vectors and handshake corner cases
// for alu_seq_core at WIDTH=8 and WIDTH=16.
module tb_alu_seq_core;
`ifdef ALU_OVF_EN
    localparam int FW = 5;
`else
    localparam int FW = 4;
`endif

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] sh;
        logic [7:0] res;
        logic [3:0] flg;
        logic       v;
        int         wt;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail = 0;

    alu_seq_core_if #(.WIDTH(8))  b8 ();
    alu_seq_core_if #(.WIDTH(16)) b16 ();

    alu_seq_core #(.WIDTH(8)) u8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b8)
    );

    alu_seq_core #(.WIDTH(16)) u16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b16)
    );

    always #5 clk = ~clk;

    task automatic check(input string name,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h",
                     name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request from IDLE and wait for out_valid.
    task automatic run_op(input  logic [3:0]    op,
                          input  logic [7:0]    a,
                          input  logic [7:0]    b,
                          input  logic [3:0]    sh,
                          input  logic          clr,
                          output logic [7:0]    res,
                          output logic [FW-1:0] flg,
                          output int            wt,
                          output logic          busy_rdy);
        b8.op_i      = op;
        b8.a_i       = a;
        b8.b_i       = b;
        b8.shamt_i   = sh;
        b8.flag_clr  = clr;
        b8.in_valid  = 1'b1;
        b8.out_ready = 1'b0;
        tick();
        b8.in_valid = 1'b0;
        b8.flag_clr = 1'b0;
        wt = 0;
        busy_rdy = 1'b0;
        while (!b8.out_valid && wt < 64) begin
            if (b8.in_ready) busy_rdy = 1'b1;
            tick();
            wt++;
        end
        if (!b8.out_valid) wt = -1;
        if (b8.in_ready) busy_rdy = 1'b1;
        res = b8.result_o;
        flg = b8.flag_o;
    endtask

    task automatic finish_op();
        b8.out_ready = 1'b1;
        tick();
        b8.out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t          vt [19];
        logic [7:0]    res;
        logic [FW-1:0] flg;
        int            wt;
        logic          busy;
        logic          seen;

        vt[0]  = '{4'h8, 8'hFF, 8'h01, 4'd0,  8'h00, 4'h7, 1'b0, 0};
        vt[1]  = '{4'hA, 8'h01, 8'h01, 4'd0,  8'h03, 4'h4, 1'b0, 0};
        vt[2]  = '{4'h9, 8'h10, 8'h20, 4'd0,  8'hF0, 4'h2, 1'b0, 0};
        vt[3]  = '{4'hB, 8'h05, 8'h02, 4'd0,  8'h02, 4'hC, 1'b0, 0};
        vt[4]  = '{4'h4, 8'hFF, 8'h00, 4'd0,  8'h00, 4'h7, 1'b0, 0};
        vt[5]  = '{4'h5, 8'h00, 8'h00, 4'd0,  8'hFF, 4'h2, 1'b0, 0};
        vt[6]  = '{4'h2, 8'h0F, 8'h00, 4'd0,  8'hF0, 4'h0, 1'b0, 0};
        vt[7]  = '{4'hF, 8'hA5, 8'h0F, 4'd0,  8'h55, 4'h4, 1'b0, 0};
        vt[8]  = '{4'hD, 8'h01, 8'h02, 4'd0,  8'h03, 4'h4, 1'b0, 0};
        vt[9]  = '{4'hE, 8'h07, 8'h00, 4'd0,  8'h07, 4'hC, 1'b0, 0};
        vt[10] = '{4'h3, 8'h00, 8'h80, 4'd0,  8'h80, 4'h8, 1'b0, 0};
        vt[11] = '{4'h1, 8'h00, 8'hFF, 4'd0,  8'h00, 4'h5, 1'b0, 0};
        vt[12] = '{4'h0, 8'h5A, 8'hA5, 4'd0,  8'h00, 4'h5, 1'b0, 0};
        vt[13] = '{4'h6, 8'h81, 8'h00, 4'd3,  8'h0A, 4'h4, 1'b0, 3};
        vt[14] = '{4'h8, 8'hFF, 8'hFF, 4'd0,  8'hFE, 4'hA, 1'b0, 0};
        vt[15] = '{4'h7, 8'h01, 8'h00, 4'd1,  8'h80, 4'hA, 1'b0, 1};
        vt[16] = '{4'h7, 8'h02, 8'h00, 4'd0,  8'h02, 4'hE, 1'b0, 0};
        vt[17] = '{4'h6, 8'h01, 8'h00, 4'd10, 8'h03, 4'h4, 1'b0, 10};
        vt[18] = '{4'h9, 8'h80, 8'h01, 4'd0,  8'h7F, 4'hC, 1'b1, 0};

        rst_n = 1'b0;
        b8.in_valid   = 1'b0;
        b8.op_i       = 4'h0;
        b8.a_i        = '0;
        b8.b_i        = '0;
        b8.shamt_i    = '0;
        b8.flag_clr   = 1'b0;
        b8.out_ready  = 1'b0;
        b16.in_valid  = 1'b0;
        b16.op_i      = 4'h0;
        b16.a_i       = '0;
        b16.b_i       = '0;
        b16.shamt_i   = '0;
        b16.flag_clr  = 1'b0;
        b16.out_ready = 1'b0;

        // Power-on reset values.
        #12;
        check("rst in_ready", 32'(b8.in_ready), 1);
        check("rst out_valid", 32'(b8.out_valid), 0);
        check("rst result", 32'(b8.result_o), 0);
        check("rst flags", 32'(b8.flag_o), 0);
        check("rst16 in_ready", 32'(b16.in_ready), 1);
        tick();
        rst_n = 1'b1;
        tick();

        // Table-driven op sequence; carry chains across vectors.
        for (int i = 0; i < 19; i++) begin
            run_op(vt[i].op, vt[i].a, vt[i].b, vt[i].sh,
                   1'b0, res, flg, wt, busy);
            check($sformatf("v%0d result", i),
                  32'(res), 32'(vt[i].res));
            check($sformatf("v%0d flags", i),
                  32'(flg[3:0]), 32'(vt[i].flg));
            check($sformatf("v%0d wait", i),
                  32'(wt), 32'(vt[i].wt));
            check($sformatf("v%0d busy in_ready", i),
                  32'(busy), 0);
`ifdef ALU_OVF_EN
            check($sformatf("v%0d overflow", i),
                  32'(flg[4]), 32'(vt[i].v));
`endif
            finish_op();
            check($sformatf("v%0d idle", i),
                  32'(b8.in_ready), 1);
        end

        // Backpressure with a competing request held on the bus.
        b8.op_i      = 4'hC;
        b8.a_i       = 8'hF0;
        b8.b_i       = 8'h3C;
        b8.in_valid  = 1'b1;
        b8.out_ready = 1'b0;
        tick();
        b8.op_i = 4'h8;
        b8.a_i  = 8'h01;
        b8.b_i  = 8'h01;
        check("bp flags", 32'(b8.flag_o[3:0]), 4);
        for (int k = 0; k < 5; k++) begin
            check("bp out_valid", 32'(b8.out_valid), 1);
            check("bp result", 32'(b8.result_o), 32'h30);
            check("bp in_ready", 32'(b8.in_ready), 0);
            tick();
        end
        b8.out_ready = 1'b1;
        tick();
        b8.out_ready = 1'b0;
        check("bp released valid", 32'(b8.out_valid), 0);
        check("bp released ready", 32'(b8.in_ready), 1);
        tick();
        b8.in_valid = 1'b0;
        check("bp second valid", 32'(b8.out_valid), 1);
        check("bp second result", 32'(b8.result_o), 32'h02);
        check("bp second flags", 32'(b8.flag_o[3:0]), 32'hC);

        // Asynchronous reset mid-cycle while holding a result.
        #3;
        rst_n = 1'b0;
        #1;
        check("arst in_ready", 32'(b8.in_ready), 1);
        check("arst out_valid", 32'(b8.out_valid), 0);
        check("arst result", 32'(b8.result_o), 0);
        check("arst flags", 32'(b8.flag_o), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Abort a rotate with reset; nothing may come out.
        run_op(4'h8, 8'hFF, 8'h01, 4'd0, 1'b0,
               res, flg, wt, busy);
        finish_op();
        b8.op_i      = 4'h6;
        b8.a_i       = 8'h81;
        b8.shamt_i   = 4'd5;
        b8.in_valid  = 1'b1;
        b8.out_ready = 1'b1;
        tick();
        b8.in_valid = 1'b0;
        check("abort in rot", 32'(b8.in_ready), 0);
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (b8.out_valid) seen = 1'b1;
            tick();
        end
        b8.out_ready = 1'b0;
        check("abort out_valid", 32'(seen), 0);
        check("abort flags", 32'(b8.flag_o), 0);

        // flag_clr together with ADDC: op sees C=0.
        run_op(4'h8, 8'hFF, 8'h01, 4'd0, 1'b0,
               res, flg, wt, busy);
        finish_op();
        check("pre clr carry", 32'(b8.flag_o[1]), 1);
        run_op(4'hA, 8'h01, 8'h01, 4'd0, 1'b1,
               res, flg, wt, busy);
        check("clr+addc result", 32'(res), 32'h02);
        check("clr+addc flags", 32'(flg[3:0]), 32'hC);
        finish_op();

        // flag_clr alone in IDLE.
        run_op(4'h8, 8'hFF, 8'h01, 4'd0, 1'b0,
               res, flg, wt, busy);
        finish_op();
        b8.flag_clr = 1'b1;
        tick();
        b8.flag_clr = 1'b0;
        check("clr only flags", 32'(b8.flag_o), 0);
        check("clr only valid", 32'(b8.out_valid), 0);
        run_op(4'hA, 8'h01, 8'h01, 4'd0, 1'b0,
               res, flg, wt, busy);
        check("addc after clr", 32'(res), 32'h02);
        finish_op();

        // WIDTH=16 carry out of ADD.
        b16.op_i      = 4'h8;
        b16.a_i       = 16'hFFFF;
        b16.b_i       = 16'h0001;
        b16.in_valid  = 1'b1;
        b16.out_ready = 1'b0;
        tick();
        b16.in_valid = 1'b0;
        check("w16 valid", 32'(b16.out_valid), 1);
        check("w16 result", 32'(b16.result_o), 0);
        check("w16 flags", 32'(b16.flag_o[3:0]), 32'h7);
        b16.out_ready = 1'b1;
        tick();
        b16.out_ready = 1'b0;
        check("w16 idle", 32'(b16.in_ready), 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
